// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: operation classes, primary opcodes, R-type
// funct codes and the field-packing helper used by the instruction encoder.
package mips_pkg;

    typedef enum logic [3:0] {
        OPC_ADD   = 4'd0,
        OPC_SUB   = 4'd1,
        OPC_AND   = 4'd2,
        OPC_OR    = 4'd3,
        OPC_SLL   = 4'd4,
        OPC_SRL   = 4'd5,
        OPC_SLT   = 4'd6,
        OPC_SLTU  = 4'd7,
        OPC_BEQ   = 4'd8,
        OPC_ADDI  = 4'd9,
        OPC_LW    = 4'd10,
        OPC_SW    = 4'd11,
        OPC_LH    = 4'd12,
        OPC_LHU   = 4'd13,
        OPC_ILL14 = 4'd14,
        OPC_ILL15 = 4'd15
    } op_class_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LHU   = 6'h25;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    function automatic logic op_is_legal(input op_class_e op);
        return (op != OPC_ILL14) && (op != OPC_ILL15);
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    // Shifts take their source from rt, so rs is zeroed; all other R-types zero shamt.
    function automatic logic [31:0] pack_instr(input op_class_e op,
                                               input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [4:0] shamt,
                                               input logic [15:0] imm);
        logic [31:0] word;
        case (op)
            OPC_ADD:  word = rtype(rs, rt, rd, 5'd0, FN_ADD);
            OPC_SUB:  word = rtype(rs, rt, rd, 5'd0, FN_SUB);
            OPC_AND:  word = rtype(rs, rt, rd, 5'd0, FN_AND);
            OPC_OR:   word = rtype(rs, rt, rd, 5'd0, FN_OR);
            OPC_SLL:  word = rtype(5'd0, rt, rd, shamt, FN_SLL);
            OPC_SRL:  word = rtype(5'd0, rt, rd, shamt, FN_SRL);
            OPC_SLT:  word = rtype(rs, rt, rd, 5'd0, FN_SLT);
            OPC_SLTU: word = rtype(rs, rt, rd, 5'd0, FN_SLTU);
            OPC_BEQ:  word = {OP_BEQ,  rs, rt, imm};
            OPC_ADDI: word = {OP_ADDI, rs, rt, imm};
            OPC_LW:   word = {OP_LW,   rs, rt, imm};
            OPC_SW:   word = {OP_SW,   rs, rt, imm};
            OPC_LH:   word = {OP_LH,   rs, rt, imm};
            OPC_LHU:  word = {OP_LHU,  rs, rt, imm};
            default:  word = 32'h0000_0000;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/mips_enc_fifo.sv
// Circular-buffer FIFO with occupancy count; no push/pop bypass, and a full
// FIFO refuses a push even when a pop happens in the same cycle.
module mips_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == {CW{1'b0}});
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= (r_wr_ptr == AW'(DEPTH - 1)) ? {AW{1'b0}} : r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == AW'(DEPTH - 1)) ? {AW{1'b0}} : r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Packs decoded MIPS fields into 32-bit instruction words and buffers them
// in a small FIFO; tracks illegal operation classes and words delivered.
module mips_instr_encoder
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [15:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             illegal_seen,
    output logic [CNT_W-1:0] out_count
);

    op_class_e        w_op;
    logic             w_accept;
    logic             w_legal;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [31:0]      w_word;
    logic             r_illegal;
    logic [CNT_W-1:0] r_count;

    assign w_op     = op_class_e'(in_op);
    assign w_legal  = op_is_legal(w_op);
    assign w_word   = pack_instr(w_op, in_rs, in_rt, in_rd, in_shamt, in_imm);
    assign in_ready = !w_full;
    assign w_accept = in_valid && in_ready;
    assign w_push   = w_accept && w_legal;
    assign out_valid = !w_empty;
    assign w_pop    = out_valid && out_ready;

    mips_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_word),
        .o_full  (w_full),
        .i_pop   (w_pop),
        .o_empty (w_empty),
        .o_data  (out_data)
    );

    // Sticky illegal-op flag and wrapping count of delivered words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
            r_count   <= {CNT_W{1'b0}};
        end else begin
            if (w_accept && !w_legal) begin
                r_illegal <= 1'b1;
            end
            if (w_pop) begin
                r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign illegal_seen = r_illegal;
    assign out_count    = r_count;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed self-checking bench for mips_instr_encoder with hand-computed words.
module tb_mips_instr_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        illegal_seen;
    logic [15:0] out_count;

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] exp_count = 16'd0;

    mips_instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .in_rd        (in_rd),
        .in_shamt     (in_shamt),
        .in_imm       (in_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .illegal_seen (illegal_seen),
        .out_count    (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bundle(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm);
        in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
    endtask

    // Accept one bundle into an empty FIFO, check the word, then pop it.
    task automatic push_check_pop(input string name, input logic [3:0] op, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                                  input logic [15:0] imm, input logic [31:0] exp);
        set_bundle(op, rs, rt, rd, sh, imm);
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            tests_failed++;
            $display("FAIL %s: got valid=%0b data=%08h, expected valid=1 data=%08h", name, out_valid, out_data, exp);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_reset();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 ||
            illegal_seen !== 1'b0 || out_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset: got valid=%0b ready=%0b data=%08h ill=%0b cnt=%0d, expected 0 1 00000000 0 0",
                     out_valid, in_ready, out_data, illegal_seen, out_count);
        end
    endtask

    task automatic test_add();
        push_check_pop("add", 4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0022_1820);
        tests_run++;
        if (out_count !== 16'd1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL add_count: got cnt=%0d valid=%0b, expected cnt=1 valid=0", out_count, out_valid);
        end
    endtask

    task automatic test_encodings();
        push_check_pop("sll",  4'd4,  5'd7,  5'd2,  5'd4, 5'd3, 16'h0,    32'h0002_20C0);
        push_check_pop("srl",  4'd5,  5'd9,  5'd2,  5'd4, 5'd3, 16'h0,    32'h0002_20C2);
        push_check_pop("or",   4'd3,  5'd1,  5'd2,  5'd3, 5'd5, 16'h0,    32'h0022_1825);
        push_check_pop("sltu", 4'd7,  5'd1,  5'd2,  5'd3, 5'd0, 16'h0,    32'h0022_182B);
        push_check_pop("lw",   4'd10, 5'd29, 5'd8,  5'd1, 5'd2, 16'h0004, 32'h8FA8_0004);
        push_check_pop("beq",  4'd8,  5'd1,  5'd0,  5'd0, 5'd0, 16'hFFFF, 32'h1020_FFFF);
        push_check_pop("sw",   4'd11, 5'd29, 5'd31, 5'd0, 5'd0, 16'h0008, 32'hAFBF_0008);
        push_check_pop("lh",   4'd12, 5'd2,  5'd3,  5'd0, 5'd0, 16'h0010, 32'h8443_0010);
        push_check_pop("lhu",  4'd13, 5'd2,  5'd3,  5'd0, 5'd0, 16'h0010, 32'h9443_0010);
        tests_run++;
        if (out_count !== exp_count) begin
            tests_failed++;
            $display("FAIL enc_count: got %0d, expected %0d", out_count, exp_count);
        end
    endtask

    task automatic test_no_bypass();
        set_bundle(4'd6, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h0022_182A) begin
            tests_failed++;
            $display("FAIL no_bypass: got valid=%0b data=%08h, expected valid=1 data=0022182a", out_valid, out_data);
        end
        step();
        out_ready = 1'b0;
        exp_count++;
        tests_run++;
        if (out_valid !== 1'b0 || out_count !== exp_count) begin
            tests_failed++;
            $display("FAIL no_bypass_pop: got valid=%0b cnt=%0d, expected valid=0 cnt=%0d", out_valid, out_count, exp_count);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        set_bundle(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        in_valid = 1'b1;
        step();
        set_bundle(4'd1, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0);
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_first: got in_ready=%0b, expected 1", in_ready);
        end
        step();
        set_bundle(4'd2, 5'd7, 5'd8, 5'd9, 5'd0, 16'h0);
        tests_run++;
        if (in_ready !== 1'b0 || out_data !== 32'h0022_1820) begin
            tests_failed++;
            $display("FAIL full_second: got in_ready=%0b data=%08h, expected 0 00221820", in_ready, out_data);
        end
        step();
        tests_run++;
        if (in_ready !== 1'b0 || out_data !== 32'h0022_1820 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_hold: got in_ready=%0b valid=%0b data=%08h, expected 0 1 00221820", in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        step();
        tests_run++;
        if (in_ready !== 1'b1 || out_data !== 32'h0085_3022) begin
            tests_failed++;
            $display("FAIL drain_first: got in_ready=%0b data=%08h, expected 1 00853022", in_ready, out_data);
        end
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'h00E8_4824) begin
            tests_failed++;
            $display("FAIL drain_second: got valid=%0b data=%08h, expected 1 00e84824", out_valid, out_data);
        end
        step();
        out_ready = 1'b0;
        exp_count = exp_count + 16'd3;
        tests_run++;
        if (out_valid !== 1'b0 || out_count !== exp_count) begin
            tests_failed++;
            $display("FAIL drain_done: got valid=%0b cnt=%0d, expected 0 %0d", out_valid, out_count, exp_count);
        end
    endtask

    task automatic test_illegal();
        set_bundle(4'd14, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1234);
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || illegal_seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal14: got valid=%0b ill=%0b, expected 0 1", out_valid, illegal_seen);
        end
        set_bundle(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || illegal_seen !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_sticky: got valid=%0b ill=%0b, expected 0 1", out_valid, illegal_seen);
        end
        push_check_pop("addi", 4'd9, 5'd0, 5'd1, 5'd7, 5'd2, 16'h0005, 32'h2001_0005);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        set_bundle(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || illegal_seen !== 1'b0 || out_data !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: got valid=%0b ill=%0b data=%08h, expected 0 0 00000000", out_valid, illegal_seen, out_data);
        end
        step();
        rst_n = 1'b1;
        exp_count = 16'd0;
        step();
        tests_run++;
        if (in_ready !== 1'b1 || out_count !== exp_count || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got in_ready=%0b cnt=%0d valid=%0b, expected 1 0 0", in_ready, out_count, out_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_bundle(4'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        test_reset();
        test_add();
        test_encodings();
        test_no_bypass();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
